// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Confreg window constants matter only when CONVERSE_WRITE_DATA_EN is defined.
package store_buffer_pkg;

    localparam logic [1:0] SB_SIZE_BYTE = 2'b00;
    localparam logic [1:0] SB_SIZE_HALF = 2'b01;
    localparam logic [1:0] SB_SIZE_WORD = 2'b10;

    localparam logic        RST_ENABLE               = 1'b1;
    localparam logic [31:0] CONF_ADDR_MASK           = 32'hffff_0000;
    localparam logic [31:0] CONF_CONVERT_CONDITION_WB = 32'hbfaf_0000;

    typedef enum logic [0:0] {
        StIdle,
        StReq
    } sb_state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } sb_entry_t;

    function automatic logic [31:0] sb_byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [3:0] sb_we_swap(input logic [3:0] we);
        return {we[0], we[1], we[2], we[3]};
    endfunction

endpackage

// File: rtl/store_buffer_lane_align.sv
// Converts store size/address into byte enables and lane-replicated data.
// Flags misaligned halves/words and the illegal size encoding.
module sb_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    always_comb begin
        we_o       = 4'b0000;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        case (size_i)
            SB_SIZE_BYTE: begin
                we_o    = 4'b0001 << addr_i;
                wdata_o = {4{data_i[7:0]}};
            end
            SB_SIZE_HALF: begin
                we_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = addr_i[0];
            end
            SB_SIZE_WORD: begin
                we_o       = 4'b1111;
                misalign_o = (addr_i != 2'b00);
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO draining to data RAM over req/ack, with word-granular load conflict detection.
// Optional macro CONVERSE_WRITE_DATA_EN swaps lanes for addresses outside the confreg window.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        st_ready_o,
    output logic        st_misalign_o,
    input  logic        ld_check_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_conflict_o,
    output logic        dram_req_o,
    output logic [31:0] dram_addr_o,
    output logic [3:0]  dram_we_o,
    output logic [31:0] dram_wdata_o,
    input  logic        dram_ack_i,
    output logic        sb_empty_o
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    sb_state_e        state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    sb_entry_t        mem_q [DEPTH];
    sb_entry_t        mem_d [DEPTH];

    logic [3:0]  al_we;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic        enq, pop;
    sb_entry_t   head;

    logic unused_ld;
    assign unused_ld = ^ld_addr_i[1:0];

    sb_lane_align u_align (
        .size_i     (st_size_i),
        .addr_i     (st_addr_i[1:0]),
        .data_i     (st_data_i),
        .we_o       (al_we),
        .wdata_o    (al_wdata),
        .misalign_o (al_misalign)
    );

    assign st_misalign_o = st_valid_i & al_misalign;
    // No full-bypass: a full buffer stays closed even if a pop happens this cycle.
    assign st_ready_o    = !rst && (count_q != FullCnt);
    assign enq           = st_valid_i & st_ready_o & !al_misalign;
    assign pop           = !rst && (state_q == StReq) && dram_ack_i;
    assign sb_empty_o    = rst || (count_q == '0);
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = '{waddr: st_addr_i[31:2], we: al_we, wdata: al_wdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (count_d != '0) state_d = StReq;
            StReq:   if (pop && (count_d == '0)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dram_req_o   = 1'b0;
        dram_addr_o  = '0;
        dram_we_o    = '0;
        dram_wdata_o = '0;
        if (!rst && (state_q == StReq)) begin
            dram_req_o   = 1'b1;
            dram_addr_o  = {head.waddr, 2'b00};
            dram_we_o    = head.we;
            dram_wdata_o = head.wdata;
`ifdef CONVERSE_WRITE_DATA_EN
            if ((dram_addr_o & CONF_ADDR_MASK) != CONF_CONVERT_CONDITION_WB) begin
                dram_we_o    = sb_we_swap(head.we);
                dram_wdata_o = sb_byte_swap(head.wdata);
            end
`endif
        end
    end

    // Entry at ring offset i from the head is live when that offset is below count.
    always_comb begin
        ld_conflict_o = 1'b0;
        if (!rst && ld_check_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q &&
                    mem_q[i].waddr == ld_addr_i[31:2]) begin
                    ld_conflict_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, drain, fill/backpressure, misalign, conflict, reset.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid_i = 1'b0;
    logic [1:0]  st_size_i = 2'b00;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_ready_o;
    logic        st_misalign_o;
    logic        ld_check_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic        ld_conflict_o;
    logic        dram_req_o;
    logic [31:0] dram_addr_o;
    logic [3:0]  dram_we_o;
    logic [31:0] dram_wdata_o;
    logic        dram_ack_i = 1'b0;
    logic        sb_empty_o;

    int n_pass = 0;
    int n_total = 0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid_i    (st_valid_i),
        .st_size_i     (st_size_i),
        .st_addr_i     (st_addr_i),
        .st_data_i     (st_data_i),
        .st_ready_o    (st_ready_o),
        .st_misalign_o (st_misalign_o),
        .ld_check_i    (ld_check_i),
        .ld_addr_i     (ld_addr_i),
        .ld_conflict_o (ld_conflict_o),
        .dram_req_o    (dram_req_o),
        .dram_addr_o   (dram_addr_o),
        .dram_we_o     (dram_we_o),
        .dram_wdata_o  (dram_wdata_o),
        .dram_ack_i    (dram_ack_i),
        .sb_empty_o    (sb_empty_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid_i = 1'b1;
        st_size_i  = sz;
        st_addr_i  = a;
        st_data_i  = d;
    endtask

    initial begin
        // Reset
        ld_check_i = 1'b1;
        ld_addr_i  = 32'h0;
        tick();
        tick();
        chk("rst_ready", 32'(st_ready_o), 0);
        chk("rst_req", 32'(dram_req_o), 0);
        chk("rst_we", 32'(dram_we_o), 0);
        chk("rst_addr", dram_addr_o, 0);
        chk("rst_wdata", dram_wdata_o, 0);
        chk("rst_empty", 32'(sb_empty_o), 1);
        chk("rst_conflict", 32'(ld_conflict_o), 0);
        ld_check_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(st_ready_o), 1);

        // SB 0xAB at 0x1000_0003
        store(2'b00, 32'h1000_0003, 32'h0000_00AB);
        #1;
        chk("sb_misalign", 32'(st_misalign_o), 0);
        chk("sb_req_before", 32'(dram_req_o), 0);
        tick();
        st_valid_i = 1'b0;
        #1;
        chk("sb_req", 32'(dram_req_o), 1);
        chk("sb_we", 32'(dram_we_o), 32'h8);
        chk("sb_wdata", dram_wdata_o, 32'hABAB_ABAB);
        chk("sb_addr", dram_addr_o, 32'h1000_0000);
        chk("sb_not_empty", 32'(sb_empty_o), 0);
        dram_ack_i = 1'b1;
        tick();
        dram_ack_i = 1'b0;
        #1;
        chk("sb_drained_req", 32'(dram_req_o), 0);
        chk("sb_drained_empty", 32'(sb_empty_o), 1);

        // SH then SW with ack held high
        dram_ack_i = 1'b1;
        store(2'b01, 32'h1000_0002, 32'h0000_1234);
        tick();
        store(2'b10, 32'h1000_0004, 32'hDEAD_BEEF);
        #1;
        chk("sh_req", 32'(dram_req_o), 1);
        chk("sh_we", 32'(dram_we_o), 32'hC);
        chk("sh_wdata", dram_wdata_o, 32'h1234_1234);
        chk("sh_addr", dram_addr_o, 32'h1000_0000);
        tick();
        st_valid_i = 1'b0;
        #1;
        chk("sw_req", 32'(dram_req_o), 1);
        chk("sw_we", 32'(dram_we_o), 32'hF);
        chk("sw_wdata", dram_wdata_o, 32'hDEAD_BEEF);
        chk("sw_addr", dram_addr_o, 32'h1000_0004);
        tick();
        chk("b2b_idle_req", 32'(dram_req_o), 0);
        chk("b2b_empty", 32'(sb_empty_o), 1);
        dram_ack_i = 1'b0;

        // Fill to DEPTH with ack low
        for (int i = 0; i < 4; i++) begin
            store(2'b10, 32'h0000_0100 + 32'(4 * i), 32'(i));
            tick();
        end
        store(2'b10, 32'h0000_0200, 32'h5555_5555);
        #1;
        chk("full_ready", 32'(st_ready_o), 0);
        chk("full_head_addr", dram_addr_o, 32'h0000_0100);
        ld_check_i = 1'b1;
        ld_addr_i  = 32'h0000_010A;
        #1;
        chk("full_conflict_mid", 32'(ld_conflict_o), 1);
        ld_check_i = 1'b0;
        tick();
        st_valid_i = 1'b0;
        #1;
        chk("full_still_closed", 32'(st_ready_o), 0);
        dram_ack_i = 1'b1;
        tick();
        chk("reopen_ready", 32'(st_ready_o), 1);
        for (int i = 1; i < 4; i++) begin
            chk("drain_req", 32'(dram_req_o), 1);
            chk("drain_addr", dram_addr_o, 32'h0000_0100 + 32'(4 * i));
            chk("drain_data", dram_wdata_o, 32'(i));
            tick();
        end
        chk("drain_done_req", 32'(dram_req_o), 0);
        chk("drain_done_empty", 32'(sb_empty_o), 1);
        dram_ack_i = 1'b0;

        // Misaligned and illegal stores
        store(2'b10, 32'h1000_0006, 32'h1111_1111);
        #1;
        chk("sw_mis_flag", 32'(st_misalign_o), 1);
        tick();
        chk("sw_mis_empty", 32'(sb_empty_o), 1);
        chk("sw_mis_req", 32'(dram_req_o), 0);
        store(2'b01, 32'h1000_0001, 32'h0);
        #1;
        chk("sh_mis_flag", 32'(st_misalign_o), 1);
        store(2'b11, 32'h1000_0000, 32'h0);
        #1;
        chk("illegal_flag", 32'(st_misalign_o), 1);
        tick();
        chk("illegal_empty", 32'(sb_empty_o), 1);
        store(2'b00, 32'h1000_0001, 32'h0);
        #1;
        chk("sb_odd_ok", 32'(st_misalign_o), 0);
        st_valid_i = 1'b0;
        #1;
        chk("mis_gated_valid", 32'(st_misalign_o), 0);

        // Load conflict
        store(2'b10, 32'h2000_0008, 32'h0000_0055);
        tick();
        st_valid_i = 1'b0;
        ld_check_i = 1'b1;
        ld_addr_i  = 32'h2000_000B;
        #1;
        chk("ld_hit", 32'(ld_conflict_o), 1);
        ld_addr_i = 32'h2000_000C;
        #1;
        chk("ld_miss", 32'(ld_conflict_o), 0);
        ld_check_i = 1'b0;
        ld_addr_i  = 32'h2000_0008;
        #1;
        chk("ld_no_check", 32'(ld_conflict_o), 0);

        // Reset with 3 pending entries while requesting
        store(2'b10, 32'h2000_0010, 32'h0000_0066);
        tick();
        store(2'b10, 32'h2000_0014, 32'h0000_0077);
        tick();
        st_valid_i = 1'b0;
        #1;
        chk("pre_rst_req", 32'(dram_req_o), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", 32'(dram_req_o), 0);
        chk("mid_rst_empty", 32'(sb_empty_o), 1);
        chk("mid_rst_ready", 32'(st_ready_o), 0);
        rst = 1'b0;
        #1;
        chk("after_rst_ready", 32'(st_ready_o), 1);
        tick();
        chk("after_rst_req", 32'(dram_req_o), 0);
        chk("after_rst_empty", 32'(sb_empty_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
